// File: rtl/mem_wb_pkg.sv
// Shared constants and load-size encodings for the MEM/WB pipeline register.
package mem_wb_pkg;

  localparam int NBITS   = 32;  // datapath width
  localparam int NREG    = 5;   // register-address width
  localparam int RETIRED = 32;  // retired-instruction counter width

  // Load-size field from EX/MEM; the unused code 2'b10 behaves as a word.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_RSVD = 2'b10,
    SZ_WORD = 2'b11
  } load_size_e;

endpackage

// File: rtl/mem_wb_load_filter.sv
// Combinational load filter: picks the addressed byte/half of the raw
// memory word (little-endian lanes) and zero- or sign-extends it.
// A misaligned half (byte_sel[0]=1) silently uses the byte_sel[1] lane.
module load_filter #(
  parameter int NBITS = mem_wb_pkg::NBITS
) (
  input  logic [NBITS-1:0] word,
  input  logic [1:0]       byte_sel,
  input  logic [1:0]       size,
  input  logic             sign_ext,
  output logic [NBITS-1:0] data
);
  import mem_wb_pkg::*;

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Lane selection and extension according to the load size.
  always_comb begin
    byte_val = 8'h00;
    half_val = byte_sel[1] ? word[31:16] : word[15:0];
    data     = word;
    case (byte_sel)
      2'd0:    byte_val = word[7:0];
      2'd1:    byte_val = word[15:8];
      2'd2:    byte_val = word[23:16];
      default: byte_val = word[31:24];
    endcase
    case (load_size_e'(size))
      SZ_BYTE: data = {{(NBITS-8){sign_ext & byte_val[7]}}, byte_val};
      SZ_HALF: data = {{(NBITS-16){sign_ext & half_val[15]}}, half_val};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register. Captures the filtered load data or ALU result,
// destination and write enable one edge after EX/MEM presents them, counts
// retired instructions and latches a sticky halt.
//
// Qualifier semantics: EX_MEM_Valid marks a real instruction; a capture
// happens on an edge with i_mips_clk_ctrl=1, i_flush=0 and no halt latched.
// i_flush overrides the enable and loads a bubble. After halt, all state is
// frozen (write enable forced low) until reset.
module mem_wb #(
  parameter int NBITS = mem_wb_pkg::NBITS,
  parameter int NREG  = mem_wb_pkg::NREG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_mips_clk_ctrl,
  input  logic             i_flush,
  input  logic             EX_MEM_Valid,
  input  logic [NBITS-1:0] EX_MEM_ALU,
  input  logic [NBITS-1:0] MEM_DatoMemoria,
  input  logic [NREG-1:0]  EX_MEM_WriteReg,
  input  logic             EX_MEM_RegWrite,
  input  logic             EX_MEM_MemtoReg,
  input  logic             EX_MEM_SignExt,
  input  logic             EX_MEM_Halt,
  input  logic [1:0]       EX_MEM_TamanoFiltro,
  output logic [NBITS-1:0] MEM_WB_Dato_o,
  output logic [NREG-1:0]  MEM_WB_WriteReg_o,
  output logic             MEM_WB_RegWrite_o,
  output logic             MEM_WB_Halt_o,
  output logic [31:0]      MEM_WB_Retired_o
);
  import mem_wb_pkg::*;

  logic [NBITS-1:0] load_data;
  logic [NBITS-1:0] wb_data;
  logic             wr_en;

  load_filter #(.NBITS(NBITS)) u_load_filter (
    .word     (MEM_DatoMemoria),
    .byte_sel (EX_MEM_ALU[1:0]),
    .size     (EX_MEM_TamanoFiltro),
    .sign_ext (EX_MEM_SignExt),
    .data     (load_data)
  );

  assign wb_data = EX_MEM_MemtoReg ? load_data : EX_MEM_ALU;
  // Writes to register 0 are dropped here so write-back never sees them.
  assign wr_en   = EX_MEM_RegWrite & EX_MEM_Valid & (EX_MEM_WriteReg != '0);

  // Pipeline register with halt freeze, flush bubble and enable-gated capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MEM_WB_Dato_o     <= '0;
      MEM_WB_WriteReg_o <= '0;
      MEM_WB_RegWrite_o <= 1'b0;
      MEM_WB_Halt_o     <= 1'b0;
      MEM_WB_Retired_o  <= '0;
    end else if (MEM_WB_Halt_o) begin
      MEM_WB_RegWrite_o <= 1'b0;
    end else if (i_flush) begin
      MEM_WB_Dato_o     <= '0;
      MEM_WB_WriteReg_o <= '0;
      MEM_WB_RegWrite_o <= 1'b0;
    end else if (i_mips_clk_ctrl) begin
      MEM_WB_Dato_o     <= wb_data;
      MEM_WB_WriteReg_o <= EX_MEM_WriteReg;
      MEM_WB_RegWrite_o <= wr_en;
      MEM_WB_Halt_o     <= EX_MEM_Valid & EX_MEM_Halt;
      if (EX_MEM_Valid) begin
        MEM_WB_Retired_o <= MEM_WB_Retired_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb.sv
// Scoreboard bench for mem_wb: the driver predicts each edge's outputs with
// a behavioural model and queues them; a monitor compares after every edge.
module tb_mem_wb;
  localparam int W = 71;  // {dato[31:0], wreg[4:0], rw, halt, retired[31:0]}

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_mips_clk_ctrl = 1'b0;
  logic        i_flush = 1'b0;
  logic        EX_MEM_Valid = 1'b0;
  logic [31:0] EX_MEM_ALU = '0;
  logic [31:0] MEM_DatoMemoria = '0;
  logic [4:0]  EX_MEM_WriteReg = '0;
  logic        EX_MEM_RegWrite = 1'b0;
  logic        EX_MEM_MemtoReg = 1'b0;
  logic        EX_MEM_SignExt = 1'b0;
  logic        EX_MEM_Halt = 1'b0;
  logic [1:0]  EX_MEM_TamanoFiltro = '0;
  logic [31:0] MEM_WB_Dato_o;
  logic [4:0]  MEM_WB_WriteReg_o;
  logic        MEM_WB_RegWrite_o;
  logic        MEM_WB_Halt_o;
  logic [31:0] MEM_WB_Retired_o;

  mem_wb dut (
    .clk                 (clk),
    .reset               (reset),
    .i_mips_clk_ctrl     (i_mips_clk_ctrl),
    .i_flush             (i_flush),
    .EX_MEM_Valid        (EX_MEM_Valid),
    .EX_MEM_ALU          (EX_MEM_ALU),
    .MEM_DatoMemoria     (MEM_DatoMemoria),
    .EX_MEM_WriteReg     (EX_MEM_WriteReg),
    .EX_MEM_RegWrite     (EX_MEM_RegWrite),
    .EX_MEM_MemtoReg     (EX_MEM_MemtoReg),
    .EX_MEM_SignExt      (EX_MEM_SignExt),
    .EX_MEM_Halt         (EX_MEM_Halt),
    .EX_MEM_TamanoFiltro (EX_MEM_TamanoFiltro),
    .MEM_WB_Dato_o       (MEM_WB_Dato_o),
    .MEM_WB_WriteReg_o   (MEM_WB_WriteReg_o),
    .MEM_WB_RegWrite_o   (MEM_WB_RegWrite_o),
    .MEM_WB_Halt_o       (MEM_WB_Halt_o),
    .MEM_WB_Retired_o    (MEM_WB_Retired_o)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard state.
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  // Reference model state.
  logic [31:0] m_dato = '0;
  logic [4:0]  m_wr = '0;
  logic        m_rw = 1'b0;
  logic        m_halt = 1'b0;
  logic [31:0] m_ret = '0;

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h expected=%h", name, act, exp);
  endtask

  function automatic logic [W-1:0] dut_vec();
    return {MEM_WB_Dato_o, MEM_WB_WriteReg_o, MEM_WB_RegWrite_o, MEM_WB_Halt_o, MEM_WB_Retired_o};
  endfunction

  // Load result from arithmetic on the word: shift the lane down, mask, extend.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [1:0] size, input logic sx);
    int unsigned v;
    if (size == 2'b00) begin
      v = (word >> (8 * (addr % 4))) & 32'hFF;
      if (sx && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'b01) begin
      v = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
      if (sx && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  // Monitor: compare queued expectation after every edge that had one.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) cmp("wb_out", dut_vec(), exp_q.pop_front());
    end
  end

  // Driver: predict the edge from current inputs, queue it, advance one cycle.
  task automatic step();
    if (m_halt) begin
      m_rw = 1'b0;
    end else if (i_flush) begin
      m_dato = '0; m_wr = '0; m_rw = 1'b0;
    end else if (i_mips_clk_ctrl) begin
      m_dato = EX_MEM_MemtoReg ? ref_load(MEM_DatoMemoria, EX_MEM_ALU, EX_MEM_TamanoFiltro, EX_MEM_SignExt)
                               : EX_MEM_ALU;
      m_wr   = EX_MEM_WriteReg;
      m_rw   = EX_MEM_RegWrite && EX_MEM_Valid && (EX_MEM_WriteReg != 0);
      m_halt = EX_MEM_Valid && EX_MEM_Halt;
      if (EX_MEM_Valid) m_ret = m_ret + 1;
    end
    exp_q.push_back({m_dato, m_wr, m_rw, m_halt, m_ret});
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before the next edge.
  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1 cmp("async_reset_clear", dut_vec(), '0);
    m_dato = '0; m_wr = '0; m_rw = 1'b0; m_halt = 1'b0; m_ret = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_load(input logic [31:0] word, input logic [31:0] addr,
                          input logic [1:0] size, input logic sx);
    i_mips_clk_ctrl = 1'b1; i_flush = 1'b0;
    EX_MEM_Valid = 1'b1; EX_MEM_RegWrite = 1'b1; EX_MEM_WriteReg = 5'd3;
    EX_MEM_MemtoReg = 1'b1; EX_MEM_Halt = 1'b0;
    MEM_DatoMemoria = word; EX_MEM_ALU = addr; EX_MEM_TamanoFiltro = size; EX_MEM_SignExt = sx;
  endtask

  task automatic rand_inputs(input bit allow_ctrl);
    i_mips_clk_ctrl     = allow_ctrl ? ($urandom_range(0, 3) != 0) : 1'b1;
    i_flush             = allow_ctrl ? ($urandom_range(0, 7) == 0) : 1'b0;
    EX_MEM_Valid        = ($urandom_range(0, 3) != 0);
    EX_MEM_ALU          = $urandom;
    MEM_DatoMemoria     = $urandom;
    EX_MEM_WriteReg     = 5'($urandom_range(0, 31));
    EX_MEM_RegWrite     = 1'($urandom_range(0, 1));
    EX_MEM_MemtoReg     = 1'($urandom_range(0, 1));
    EX_MEM_SignExt      = 1'($urandom_range(0, 1));
    EX_MEM_TamanoFiltro = 2'($urandom_range(0, 3));
    EX_MEM_Halt         = 1'b0;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    cmp("reset_state", dut_vec(), '0);
    reset = 1'b1;

    // Byte loads, lane 1 of 0x1234_80FF.
    set_load(32'h1234_80FF, 32'h0000_1001, 2'b00, 1'b1); step();
    cmp("lb_sign", 71'(MEM_WB_Dato_o), 71'(32'hFFFF_FF80));
    set_load(32'h1234_80FF, 32'h0000_1001, 2'b00, 1'b0); step();
    cmp("lb_zero", 71'(MEM_WB_Dato_o), 71'(32'h0000_0080));

    // Half loads, including a misaligned upper half.
    set_load(32'h8001_7FFE, 32'h0000_0002, 2'b01, 1'b1); step();
    cmp("lh_upper", 71'(MEM_WB_Dato_o), 71'(32'hFFFF_8001));
    set_load(32'h8001_7FFE, 32'h0000_0000, 2'b01, 1'b1); step();
    cmp("lh_lower", 71'(MEM_WB_Dato_o), 71'(32'h0000_7FFE));
    set_load(32'h8001_7FFE, 32'h0000_0003, 2'b01, 1'b1); step();
    cmp("lh_misaligned", 71'(MEM_WB_Dato_o), 71'(32'hFFFF_8001));

    // Word loads, both word codes.
    set_load(32'hDEAD_BEEF, 32'h0000_0002, 2'b11, 1'b1); step();
    cmp("lw_11", 71'(MEM_WB_Dato_o), 71'(32'hDEAD_BEEF));
    set_load(32'hCAFE_F00D, 32'h0000_0001, 2'b10, 1'b1); step();
    cmp("lw_10", 71'(MEM_WB_Dato_o), 71'(32'hCAFE_F00D));

    // R-type to register 0.
    set_load(32'h0, 32'h55, 2'b11, 1'b0);
    EX_MEM_MemtoReg = 1'b0; EX_MEM_WriteReg = 5'd0; step();
    cmp("rtype_r0_rw", 71'(MEM_WB_RegWrite_o), 71'(0));
    cmp("rtype_r0_dato", 71'(MEM_WB_Dato_o), 71'(32'h55));

    // Stall for three edges, then flush with enable high.
    i_mips_clk_ctrl = 1'b0; EX_MEM_ALU = 32'h77; EX_MEM_WriteReg = 5'd9;
    repeat (3) step();
    cmp("stall_dato", 71'(MEM_WB_Dato_o), 71'(32'h55));
    cmp("stall_count", 71'(MEM_WB_Retired_o), 71'(8));
    i_mips_clk_ctrl = 1'b1; i_flush = 1'b1; step();
    cmp("flush_bubble", 71'({MEM_WB_Dato_o, MEM_WB_WriteReg_o, MEM_WB_RegWrite_o}), 71'(0));
    cmp("flush_count", 71'(MEM_WB_Retired_o), 71'(8));
    i_flush = 1'b0;

    // Randomized traffic with stalls and flushes.
    for (int i = 0; i < 250; i++) begin
      rand_inputs(1'b1);
      step();
    end

    // Reset asserted in the middle of a stall.
    rand_inputs(1'b0); i_mips_clk_ctrl = 1'b0; step();
    pulse_reset();

    // Halt after four valid instructions; halt itself is counted.
    for (int i = 0; i < 4; i++) begin
      rand_inputs(1'b0); EX_MEM_Valid = 1'b1; step();
    end
    rand_inputs(1'b0); EX_MEM_Valid = 1'b1; EX_MEM_Halt = 1'b1; step();
    cmp("halt_count", 71'(MEM_WB_Retired_o), 71'(5));
    cmp("halt_flag", 71'(MEM_WB_Halt_o), 71'(1));
    for (int i = 0; i < 5; i++) begin
      rand_inputs(1'b0); EX_MEM_Valid = 1'b1; EX_MEM_RegWrite = 1'b1;
      EX_MEM_WriteReg = 5'd7; step();
    end
    cmp("post_halt_count", 71'(MEM_WB_Retired_o), 71'(5));
    cmp("post_halt_rw", 71'(MEM_WB_RegWrite_o), 71'(0));

    // Reset after halt, then a normal capture.
    pulse_reset();
    set_load(32'h0, 32'h1234, 2'b11, 1'b0); EX_MEM_MemtoReg = 1'b0; step();
    cmp("after_halt_reset", 71'({MEM_WB_Dato_o, MEM_WB_RegWrite_o, MEM_WB_Retired_o}),
        71'({32'h1234, 1'b1, 32'd1}));

    // More random traffic, ended by an async reset mid-sequence.
    for (int i = 0; i < 40; i++) begin
      rand_inputs(1'b1);
      step();
    end
    pulse_reset();

    repeat (3) @(negedge clk);
    cmp("queue_drained", 71'(exp_q.size()), 71'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_wb.md
MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 Parameter NBITS, default 32: datapath width.
REQ-002 Parameter NREG, default 5: register-address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 i_mips_clk_ctrl  in  1  pipeline advance enable; 1 = capture, 0 = hold.
REQ-006 i_flush  in  1  insert bubble at next edge.
REQ-007 EX_MEM_Valid  in  1  instruction in MEM is real (not bubble).
REQ-008 EX_MEM_ALU  in  NBITS  ALU result / load address.
REQ-009 MEM_DatoMemoria  in  NBITS  raw aligned word read by MEM stage, same cycle.
REQ-010 EX_MEM_WriteReg  in  NREG  destination register.
REQ-011 EX_MEM_RegWrite, EX_MEM_MemtoReg, EX_MEM_SignExt, EX_MEM_Halt  in  1 each  control bits.
REQ-012 EX_MEM_TamanoFiltro  in  2  load size: 00 byte, 01 half, 11 word, 10 treated as word.
REQ-013 MEM_WB_Dato_o  out  NBITS  write-back data.
REQ-014 MEM_WB_WriteReg_o  out  NREG; MEM_WB_RegWrite_o  out  1.
REQ-015 MEM_WB_Halt_o  out  1  sticky halt reached write-back.
REQ-016 MEM_WB_Retired_o  out  32  retired-instruction count (debug).

Function
REQ-017 Latency SHALL be exactly one clk edge from EX_MEM inputs to MEM_WB outputs; all outputs registered.
REQ-018 Load filter: byte lane = ALU[1:0] (lane 0 = bits 7:0, little-endian); half lane = ALU[1]; zero- or sign-extend per EX_MEM_SignExt; word passes unchanged.
REQ-019 MEM_WB_Dato_o SHALL capture filtered memory data when MemtoReg=1, else EX_MEM_ALU.
REQ-020 MEM_WB_RegWrite_o SHALL capture RegWrite AND Valid AND (WriteReg != 0).
REQ-021 i_mips_clk_ctrl=0 and i_flush=0: all state holds.
REQ-022 i_flush=1 (any enable value): next edge loads bubble -- RegWrite_o=0, WriteReg_o=0, Dato_o=0, counter unchanged; flush has priority over enable.
REQ-023 Retired counter increments by 1 on each capturing edge with Valid=1, not flushed, Halt_o=0; wraps FFFF_FFFF -> 0.
REQ-024 Capture with Valid=1 and EX_MEM_Halt=1 SHALL set MEM_WB_Halt_o; halt instruction itself counted.
REQ-025 Once Halt_o=1: outputs and counter frozen, RegWrite_o forced 0 from next edge, until reset.
REQ-026 Misaligned half (ALU[0]=1) uses ALU[1] lane only; no exception.

Reset
REQ-027 reset=0 SHALL immediately clear all outputs and state to 0, independent of clk.
REQ-028 Reset asserted mid-stall or post-halt SHALL fully clear; first capture after release proceeds normally.

Structure
REQ-029 Shared package: NBITS, NREG, size encodings (BYTE=00, HALF=01, WORD=11).
REQ-030 Sub-module load_filter (combinational: word, ALU[1:0], size, SignExt -> filtered data); rest in mem_wb.

Verification
REQ-031 Load byte: Dato=0x1234_80FF, ALU[1:0]=01, size 00, SignExt=1, MemtoReg=1 -> Dato_o=0xFFFF_FF80 after one edge; SignExt=0 -> 0x0000_0080.
REQ-032 Load half: Dato=0x8001_7FFE, ALU[1]=1, SignExt=1 -> 0xFFFF_8001; ALU[1]=0 -> 0x0000_7FFE.
REQ-033 R-type to $0: ALU=0x55, WriteReg=0, RegWrite=1 -> RegWrite_o=0, Dato_o=0x55.
REQ-034 Stall/flush: enable=0 for 3 edges -> outputs and count unchanged; then i_flush=1 -> bubble, count unchanged.
REQ-035 Halt: 4 valid instructions then Halt -> Retired_o=5, Halt_o=1; further valid inputs -> count stays 5, RegWrite_o=0.
REQ-036 Async reset: reset=0 between edges mid-sequence -> all outputs 0 before next edge.
